xadac_vmacc_seq: RTL and testbench
==================================

Name: xadac_vmacc_seq

Overview:
- Multi-cycle, parametrised successor to the single-cycle XADAC vector multiply-accumulate unit; sits on the execute side of the XADAC accelerator port.
- Dot-product accumulates `ElemWidth` elements of vs0 x vs1 into the `SumWidth` lanes of vs2.
- Computes `Lanes` products per cycle, so area scales with `Lanes` instead of with the vector width.
- Adds a selectable group length `jlen` (1, 2 or 4) and four signedness modes.
- Handles one instruction at a time, with a registered response and full back-pressure.

Parameters:
- `DataWidth`, 128, vector register width in bits.
- `SumWidth`, 32, accumulator lane width; `DataWidth` must be a multiple of it.
- `ElemWidth`, 8, multiplicand element width.
- `Lanes`, 4, multipliers per cycle; power of two, 1..`DataWidth`/`ElemWidth`.
- `IdWidth`, 4, instruction tag width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute request valid.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `req_id`  in  `IdWidth`  instruction tag.
- `req_jlen`  in  3  group length; legal values are 1, 2 and 4.
- `req_mode`  in  2  signedness: 0 = s0*u1, 1 = s0*s1, 2 = u0*u1, 3 = u0*s1.
- `req_vd_addr`  in  5  destination register index.
- `req_vs0`, `req_vs1`, `req_vs2`  in  `DataWidth`  multiplicands and accumulator source.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid` and `rsp_ready` are both high.
- `rsp_id`  out  `IdWidth`  echoed tag.
- `rsp_vd_addr`  out  5  echoed destination.
- `rsp_vd_data`  out  `DataWidth`  result.
- `rsp_vd_write`  out  1  1 = write vd; 0 = illegal `jlen`, no write.
- `busy`  out  1  high in COMPUTE or DONE.

Behaviour:
- Derived quantities:
  - NACC = `DataWidth`/`SumWidth`.
  - P = NACC*`jlen` (products used).
  - NCYC = ceil(P/`Lanes`).
- FSM states: IDLE, COMPUTE, DONE.
- Reset: state IDLE, counter 0, `rsp_valid`=0, `busy`=0. All `rsp_*` data registers are 0.
- Reset asserted mid-operation aborts the instruction. No response is produced, and the request is not re-issued.
- `req_ready` = (state==IDLE) || (state==DONE && `rsp_ready`). The second term gives back-to-back acceptance in the same cycle a response retires.
- Acceptance latches id, `jlen`, mode, vd_addr, vs0, vs1 and vs2; vs2 becomes the accumulator image.
- Next state after acceptance:
  - Legal `jlen`: COMPUTE with counter c=0.
  - Illegal `jlen` (0, 3, 5-7): DONE directly, with `rsp_vd_data`=vs2 and `rsp_vd_write`=0. `rsp_valid` rises 1 cycle after acceptance.
- COMPUTE cycle c, for each lane l with k = c*`Lanes`+l and k<P:
  - Element k of vs0 and element k of vs1 (bits k*`ElemWidth` +: `ElemWidth`) are multiplied.
  - The product is added into accumulator i = k/`jlen`. Several lanes may hit the same accumulator in one cycle and must all be summed.
  - Lanes with k>=P contribute 0.
- Arithmetic:
  - Each operand is extended to `ElemWidth`+1 bits (sign or zero per mode).
  - The signed product is sign-extended to `SumWidth`.
  - Accumulation wraps modulo 2^`SumWidth` (two's complement); no saturation.
- Leaving COMPUTE: at c==NCYC-1 the state goes to DONE, registering `rsp_vd_data` and setting `rsp_vd_write`=1.
- Latency: `rsp_valid` rises exactly NCYC+1 cycles after the acceptance edge. Example: `DataWidth`=128, `Lanes`=4 gives 2 cycles for `jlen`=1 and 5 cycles for `jlen`=4.
- Bytes beyond P are ignored; vs2 lanes are always all updated, since P covers NACC groups.
- DONE:
  - All `rsp_*` outputs are held stable while `rsp_ready`=0.
  - On `rsp_ready`: go to IDLE, or to COMPUTE/DONE if a new request is accepted in the same cycle.
- `req_*` inputs are ignored outside acceptance cycles. Changes to them while busy have no effect.

Test Plan:
- `jlen`=1, mode 0, vs0 byte0=0xFF, vs1 byte0=0xFF, vs2 word0=10, all other bytes 0 -> word0=0xFFFFFF0B (-245), other words unchanged, `rsp_vd_write`=1, `rsp_valid` 2 cycles after accept.
- `jlen`=4, mode 2, all vs0 bytes 0x02, all vs1 bytes 0x03, vs2=0 -> every word=24, `rsp_valid` 5 cycles after accept, `busy` high throughout.
- Modes on `jlen`=1, byte0 0x80 x 0x80, vs2=0 -> word0 per mode:
  - mode 1 = 16384 (0x00004000);
  - mode 0 = -16384 (0xFFFFC000);
  - mode 2 = 0x00004000;
  - mode 3 = 0xFFFFC000.
- Wrap and illegal `jlen`:
  - Wrap: vs2 word0=0x7FFFFFFF, bytes 0x01 x 0x01, `jlen`=1 -> word0=0x80000000.
  - Illegal: `jlen`=3 -> `rsp_vd_write`=0, `rsp_vd_data`=vs2, 1-cycle latency.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in DONE -> `rsp_*` stable, `req_ready`=0. Then raise `rsp_ready` with `req_valid` high -> new request accepted in the same cycle, its tag returned next.
- Reset mid-operation: assert `rst` during COMPUTE of a `jlen`=4 op -> next cycle IDLE, `rsp_valid`=0, `busy`=0, `req_ready`=1. A following op yields the correct result.

Source files
------------

// File: rtl/xadac_vmacc_seq_if.sv
// Request/response bundle between the XADAC execute port and the sequential vector MAC.
// master = requester side, slave = the MAC unit.
interface xadac_vmacc_seq_if #(
  parameter int DataWidth = 128,
  parameter int IdWidth   = 4
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [IdWidth-1:0]   req_id;
  logic [2:0]           req_jlen;
  logic [1:0]           req_mode;
  logic [4:0]           req_vd_addr;
  logic [DataWidth-1:0] req_vs0;
  logic [DataWidth-1:0] req_vs1;
  logic [DataWidth-1:0] req_vs2;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IdWidth-1:0]   rsp_id;
  logic [4:0]           rsp_vd_addr;
  logic [DataWidth-1:0] rsp_vd_data;
  logic                 rsp_vd_write;

  modport master (
    output req_valid, req_id, req_jlen, req_mode, req_vd_addr, req_vs0, req_vs1, req_vs2,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_vd_addr, rsp_vd_data, rsp_vd_write
  );

  modport slave (
    input  req_valid, req_id, req_jlen, req_mode, req_vd_addr, req_vs0, req_vs1, req_vs2,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_vd_addr, rsp_vd_data, rsp_vd_write
  );
endinterface

// File: rtl/xadac_vmacc_seq.sv
// Multi-cycle vector dot-product MAC: Lanes element products per cycle are summed into
// the SumWidth accumulator lanes of vs2, grouped by jlen (1, 2 or 4).
module xadac_vmacc_seq #(
  parameter int DataWidth = 128,
  parameter int SumWidth  = 32,
  parameter int ElemWidth = 8,
  parameter int Lanes     = 4,
  parameter int IdWidth   = 4
) (
  input  logic               clk,
  input  logic               rst,
  xadac_vmacc_seq_if.slave   bus,
  output logic               busy
);
  localparam int NAcc  = DataWidth / SumWidth;
  localparam int NElem = DataWidth / ElemWidth;
  localparam int CntW  = $clog2(4 * NAcc + 1);
  localparam int ProdW = 2 * (ElemWidth + 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [2:0]           jlen_q, jlen_d;
  logic [1:0]           mode_q, mode_d;
  logic [4:0]           vd_q, vd_d;
  logic [DataWidth-1:0] vs0_q, vs0_d;
  logic [DataWidth-1:0] vs1_q, vs1_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic                 write_q, write_d;

  logic                 accept_w;
  logic                 jlen_legal_w;
  logic                 last_w;
  logic [1:0]           jshift_w;
  logic [31:0]          p_w;
  logic [DataWidth-1:0] acc_sum_w;
  logic [31:0]          k_w       [Lanes];
  logic [31:0]          acc_idx_w [Lanes];
  logic                 live_w    [Lanes];
  logic [SumWidth-1:0]  prod_w    [Lanes];

  assign bus.req_ready    = (state_q == IDLE) || (state_q == DONE && bus.rsp_ready);
  assign accept_w         = bus.req_valid && bus.req_ready;
  assign jlen_legal_w     = (bus.req_jlen == 3'd1) || (bus.req_jlen == 3'd2) || (bus.req_jlen == 3'd4);
  assign bus.rsp_valid    = (state_q == DONE);
  assign busy             = (state_q != IDLE);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_vd_addr  = vd_q;
  assign bus.rsp_vd_data  = acc_q;
  assign bus.rsp_vd_write = write_q;

  // jlen is 1, 2 or 4 while computing, so the group index is a right shift
  assign jshift_w = jlen_q[2] ? 2'd2 : (jlen_q[1] ? 2'd1 : 2'd0);
  assign p_w      = 32'(NAcc) * 32'(jlen_q);
  assign last_w   = ((32'(cnt_q) + 32'd1) * 32'(Lanes)) >= p_w;

  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_lane
      logic [ElemWidth-1:0]  a_raw, b_raw;
      logic [ElemWidth:0]    a_x, b_x;
      logic signed [ProdW-1:0] prod;

      assign k_w[gi]       = 32'(cnt_q) * 32'(Lanes) + 32'(gi);
      assign live_w[gi]    = (k_w[gi] < p_w) && (k_w[gi] < 32'(NElem));
      assign acc_idx_w[gi] = k_w[gi] >> jshift_w;
      assign a_raw         = ElemWidth'(vs0_q >> (k_w[gi] * 32'(ElemWidth)));
      assign b_raw         = ElemWidth'(vs1_q >> (k_w[gi] * 32'(ElemWidth)));
      // mode[1] selects unsigned vs0, mode[0] selects signed vs1
      assign a_x           = {mode_q[1] ? 1'b0 : a_raw[ElemWidth-1], a_raw};
      assign b_x           = {mode_q[0] ? b_raw[ElemWidth-1] : 1'b0, b_raw};
      assign prod          = $signed(a_x) * $signed(b_x);
      assign prod_w[gi]    = live_w[gi] ? SumWidth'(prod) : '0;
    end

    for (gi = 0; gi < NAcc; gi++) begin : g_acc
      logic [SumWidth-1:0] sum;
      always_comb begin
        sum = acc_q[gi*SumWidth +: SumWidth];
        for (int l = 0; l < Lanes; l++) begin
          if (live_w[l] && acc_idx_w[l] == 32'(gi)) begin
            sum = sum + prod_w[l];
          end
        end
      end
      assign acc_sum_w[gi*SumWidth +: SumWidth] = sum;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    jlen_d  = jlen_q;
    mode_d  = mode_q;
    vd_d    = vd_q;
    vs0_d   = vs0_q;
    vs1_d   = vs1_q;
    acc_d   = acc_q;
    write_d = write_q;
    case (state_q)
      COMPUTE: begin
        acc_d = acc_sum_w;
        cnt_d = cnt_q + 1'b1;
        if (last_w) begin
          state_d = DONE;
          write_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: ;
    endcase
    // a new request may overwrite the just-retired response in the same cycle
    if (accept_w) begin
      id_d   = bus.req_id;
      jlen_d = bus.req_jlen;
      mode_d = bus.req_mode;
      vd_d   = bus.req_vd_addr;
      vs0_d  = bus.req_vs0;
      vs1_d  = bus.req_vs1;
      acc_d  = bus.req_vs2;
      cnt_d  = '0;
      if (jlen_legal_w) begin
        state_d = COMPUTE;
      end else begin
        state_d = DONE;
        write_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      jlen_q  <= '0;
      mode_q  <= '0;
      vd_q    <= '0;
      vs0_q   <= '0;
      vs1_q   <= '0;
      acc_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      jlen_q  <= jlen_d;
      mode_q  <= mode_d;
      vd_q    <= vd_d;
      vs0_q   <= vs0_d;
      vs1_q   <= vs1_d;
      acc_q   <= acc_d;
      write_q <= write_d;
    end
  end
endmodule

// File: tb/tb_xadac_vmacc_seq.sv
// Bench for xadac_vmacc_seq: directed vector table, back-pressure and reset sequences,
// then randomized ops checked against an arithmetic dot-product model.
module tb_xadac_vmacc_seq;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  xadac_vmacc_seq_if #(.DataWidth(DW), .IdWidth(4)) bus ();

  xadac_vmacc_seq #(
    .DataWidth(DW), .SumWidth(32), .ElemWidth(8), .Lanes(4), .IdWidth(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]    jlen;
    logic [1:0]    mode;
    logic [DW-1:0] vs0;
    logic [DW-1:0] vs1;
    logic [DW-1:0] vs2;
    logic [DW-1:0] exp_data;
    logic          exp_write;
    int            exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each accumulator word i gets sum over j<jlen of elem(i*jlen+j) products.
  function automatic logic [DW-1:0] model(input logic [2:0] jlen, input logic [1:0] mode,
                                          input logic [DW-1:0] vs0, input logic [DW-1:0] vs1,
                                          input logic [DW-1:0] vs2);
    logic [DW-1:0] r;
    byte           sa, sb;
    int            a, b;
    logic [31:0]   s;
    int            k;
    r = vs2;
    if (jlen != 3'd1 && jlen != 3'd2 && jlen != 3'd4) return r;
    for (int i = 0; i < 4; i++) begin
      s = vs2[i*32 +: 32];
      for (int j = 0; j < int'(jlen); j++) begin
        k  = i * int'(jlen) + j;
        sa = vs0[k*8 +: 8];
        sb = vs1[k*8 +: 8];
        a  = mode[1] ? int'(vs0[k*8 +: 8]) : int'(sa);
        b  = mode[0] ? int'(sb) : int'(vs1[k*8 +: 8]);
        s  = s + 32'(a * b);
      end
      r[i*32 +: 32] = s;
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] jlen);
    if (jlen != 3'd1 && jlen != 3'd2 && jlen != 3'd4) return 1;
    return (4 * int'(jlen) + 3) / 4 + 1;
  endfunction

  task automatic drive_req(input logic [3:0] id, input logic [2:0] jlen, input logic [1:0] mode,
                           input logic [4:0] vd, input logic [DW-1:0] vs0,
                           input logic [DW-1:0] vs1, input logic [DW-1:0] vs2);
    bus.req_valid   = 1'b1;
    bus.req_id      = id;
    bus.req_jlen    = jlen;
    bus.req_mode    = mode;
    bus.req_vd_addr = vd;
    bus.req_vs0     = vs0;
    bus.req_vs1     = vs1;
    bus.req_vs2     = vs2;
  endtask

  // Drop valid and scramble the request fields; the DUT must have latched them already.
  task automatic scramble_req();
    bus.req_valid   = 1'b0;
    bus.req_id      = 4'($urandom);
    bus.req_jlen    = 3'($urandom);
    bus.req_mode    = 2'($urandom);
    bus.req_vd_addr = 5'($urandom);
    bus.req_vs0     = {$urandom, $urandom, $urandom, $urandom};
    bus.req_vs1     = {$urandom, $urandom, $urandom, $urandom};
    bus.req_vs2     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called #1 after the accepting edge; returns edges counted from acceptance (inclusive).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin
      check("busy_while_compute", busy, 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid, required one within 64 cycles");
    end
  endtask

  task automatic retire();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("idle_after_retire", {busy, bus.rsp_valid}, 2'b00);
  endtask

  task automatic run_op(input string name, input logic [3:0] id, input logic [2:0] jlen,
                        input logic [1:0] mode, input logic [4:0] vd, input logic [DW-1:0] vs0,
                        input logic [DW-1:0] vs1, input logic [DW-1:0] vs2, input int stall,
                        input logic [DW-1:0] exp_data, input logic exp_write, input int exp_lat);
    int            lat;
    logic [DW-1:0] held;
    @(negedge clk);
    drive_req(id, jlen, mode, vd, vs0, vs1, vs2);
    #1 check({name, "_req_ready"}, bus.req_ready, 1'b1);
    @(posedge clk); #1;
    scramble_req();
    wait_rsp(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, bus.rsp_vd_data, exp_data);
    check({name, "_write"}, bus.rsp_vd_write, exp_write);
    check({name, "_id"}, bus.rsp_id, id);
    check({name, "_vd"}, bus.rsp_vd_addr, vd);
    held = bus.rsp_vd_data;
    repeat (stall) begin
      @(posedge clk); #1;
      check({name, "_stall_hold"}, {bus.rsp_valid, bus.rsp_vd_data}, {1'b1, held});
    end
    $display("[TB] op %s id=%0d jlen=%0d mode=%0d lat=%0d data=%h wr=%0d", name, id, jlen, mode,
             lat, bus.rsp_vd_data, bus.rsp_vd_write);
    retire();
  endtask

  vec_t tbl[8];
  logic [2:0] jlen_pool[8];

  initial begin
    int            lat;
    logic [DW-1:0] vs0, vs1, vs2, held;
    logic [2:0]    jl;
    logic [1:0]    md;

    tbl[0] = '{3'd1, 2'd0, 128'hFF, 128'hFF, 128'h0A, 128'hFFFFFF0B, 1'b1, 2};
    tbl[1] = '{3'd4, 2'd2, {16{8'h02}}, {16{8'h03}}, 128'h0, {4{32'd24}}, 1'b1, 5};
    tbl[2] = '{3'd1, 2'd1, 128'h80, 128'h80, 128'h0, 128'h00004000, 1'b1, 2};
    tbl[3] = '{3'd1, 2'd0, 128'h80, 128'h80, 128'h0, 128'hFFFFC000, 1'b1, 2};
    tbl[4] = '{3'd1, 2'd2, 128'h80, 128'h80, 128'h0, 128'h00004000, 1'b1, 2};
    tbl[5] = '{3'd1, 2'd3, 128'h80, 128'h80, 128'h0, 128'hFFFFC000, 1'b1, 2};
    tbl[6] = '{3'd1, 2'd1, 128'h01, 128'h01, 128'h7FFFFFFF, 128'h80000000, 1'b1, 2};
    tbl[7] = '{3'd3, 2'd1, {16{8'h11}}, {16{8'h22}}, 128'h12345678_9ABCDEF0_0BADF00D_CAFEBABE,
               128'h12345678_9ABCDEF0_0BADF00D_CAFEBABE, 1'b0, 1};
    jlen_pool = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd3};

    rst           = 1'b1;
    bus.rsp_ready = 1'b0;
    scramble_req();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.rsp_valid, busy, bus.req_ready, bus.rsp_vd_write},
          4'b0010);
    check("reset_rsp_data", bus.rsp_vd_data, '0);
    check("reset_rsp_tags", {bus.rsp_id, bus.rsp_vd_addr}, '0);
    @(negedge clk);
    rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), 4'(i + 1), tbl[i].jlen, tbl[i].mode, 5'(i + 3),
             tbl[i].vs0, tbl[i].vs1, tbl[i].vs2, 0, tbl[i].exp_data, tbl[i].exp_write,
             tbl[i].exp_lat);
    end
    run_op("jlen2", 4'd12, 3'd2, 2'd1, 5'd7, {16{8'hFF}}, {16{8'h01}}, {4{32'd5}}, 1,
           {4{32'd3}}, 1'b1, 3);

    // back-pressure, then back-to-back accept on the retiring cycle
    @(negedge clk);
    drive_req(4'd5, 3'd2, 3'd0, 5'd9, {16{8'h07}}, {16{8'h09}}, 128'h0);
    @(posedge clk); #1;
    scramble_req();
    wait_rsp(lat);
    check("bp_data", bus.rsp_vd_data, model(3'd2, 2'd0, {16{8'h07}}, {16{8'h09}}, 128'h0));
    held = bus.rsp_vd_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_vd_data},
            {1'b1, 1'b0, 4'd5, held});
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive_req(4'd9, 3'd1, 2'd2, 5'd2, 128'h03, 128'h05, 128'h0);
    #1 check("b2b_req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    scramble_req();
    check("b2b_accepted", {bus.rsp_valid, busy}, 2'b01);
    wait_rsp(lat);
    check("b2b_id", bus.rsp_id, 4'd9);
    check("b2b_data", bus.rsp_vd_data, 128'd15);
    check("b2b_latency", lat, 2);
    $display("[TB] op b2b id=%0d lat=%0d data=%h", bus.rsp_id, lat, bus.rsp_vd_data);
    retire();

    // reset during COMPUTE of a jlen=4 op
    @(negedge clk);
    drive_req(4'd3, 3'd4, 2'd1, 5'd1, {16{8'h05}}, {16{8'h05}}, 128'h0);
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    check("mid_busy", {busy, bus.rsp_valid}, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_state", {bus.rsp_valid, busy, bus.req_ready}, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_rsp_after_abort", bus.rsp_valid, 1'b0);
    end
    $display("[TB] op mid_reset aborted");
    run_op("post_reset", 4'd4, tbl[0].jlen, tbl[0].mode, 5'd4, tbl[0].vs0, tbl[0].vs1,
           tbl[0].vs2, 0, tbl[0].exp_data, tbl[0].exp_write, tbl[0].exp_lat);

    // randomized ops against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      jl  = jlen_pool[$urandom_range(0, 7)];
      md  = 2'($urandom);
      vs0 = {$urandom, $urandom, $urandom, $urandom};
      vs1 = {$urandom, $urandom, $urandom, $urandom};
      vs2 = {$urandom, $urandom, $urandom, $urandom};
      run_op($sformatf("rnd%0d", n), 4'($urandom), jl, md, 5'($urandom), vs0, vs1, vs2,
             int'($urandom_range(0, 3)), model(jl, md, vs0, vs1, vs2),
             (jl == 3'd1 || jl == 3'd2 || jl == 3'd4), model_lat(jl));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
